// File: rtl/score_pkg.sv
// Shared constants and types for the BCD score counter and its seven-segment decoder.
package score_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0011000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef logic [BCD_W-1:0] bcd_digit_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
module seg7_decode
    import score_pkg::*;
(
    input  bcd_digit_t       bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_bcd_counter.sv
// Saturating multi-digit BCD hit counter with per-digit seven-segment outputs.
// Optional miss penalty (decrement with floor at zero) enabled by SCORE_PENALTY_EN.
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int N_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic [N_CH-1:0]           pb,
    input  logic [N_CH-1:0]           mole,
    output logic [BCD_W*N_DIGITS-1:0] score_bcd,
    output logic [SEG_W*N_DIGITS-1:0] seg,
    output logic                      hit_pulse,
`ifdef SCORE_PENALTY_EN
    output logic                      miss_pulse,
`endif
    output logic                      sat
);

    localparam int SCORE_W = BCD_W * N_DIGITS;

    logic [N_CH-1:0]    pb_q;
    logic [N_CH-1:0]    press;
    logic               hit;
    logic               at_max;
    logic [SCORE_W-1:0] score_next;
    logic               hit_next;

    // True when every digit of v equals d.
    function automatic logic all_digits(input logic [SCORE_W-1:0] v, input bcd_digit_t d);
        logic r;
        r = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (v[i*BCD_W +: BCD_W] != d) r = 1'b0;
        end
        return r;
    endfunction

    // BCD +1 with ripple carry; caller guarantees v is not all nines.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               carry;
        bcd_digit_t         d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            d = v[i*BCD_W +: BCD_W];
            if (carry) begin
                if (d == 4'd9) begin
                    r[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    r[i*BCD_W +: BCD_W] = d + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef SCORE_PENALTY_EN
    logic miss;
    logic miss_next;
    logic at_zero;

    // BCD -1 with ripple borrow; caller guarantees v is not zero.
    function automatic logic [SCORE_W-1:0] bcd_dec(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               borrow;
        bcd_digit_t         d;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            d = v[i*BCD_W +: BCD_W];
            if (borrow) begin
                if (d == 4'd0) begin
                    r[i*BCD_W +: BCD_W] = 4'd9;
                end else begin
                    r[i*BCD_W +: BCD_W] = d - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign miss    = |(press & ~mole);
    assign at_zero = all_digits(score_bcd, 4'd0);
`endif

    assign press  = pb & ~pb_q;
    assign hit    = |(press & mole);
    assign at_max = all_digits(score_bcd, 4'd9);

    always_comb begin
        score_next = score_bcd;
        hit_next   = 1'b0;
`ifdef SCORE_PENALTY_EN
        miss_next  = 1'b0;
`endif
        if (clr) begin
            score_next = '0;
        end else if (hit) begin
            hit_next = 1'b1;
            if (!at_max) score_next = bcd_inc(score_bcd);
`ifdef SCORE_PENALTY_EN
        end else if (miss) begin
            // A miss at the floor still pulses, it just cannot go lower.
            miss_next = 1'b1;
            if (!at_zero) score_next = bcd_dec(score_bcd);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pb_q       <= '0;
            score_bcd  <= '0;
            hit_pulse  <= 1'b0;
            sat        <= 1'b0;
`ifdef SCORE_PENALTY_EN
            miss_pulse <= 1'b0;
`endif
        end else begin
            pb_q       <= pb;
            score_bcd  <= score_next;
            hit_pulse  <= hit_next;
            sat        <= all_digits(score_next, 4'd9);
`ifdef SCORE_PENALTY_EN
            miss_pulse <= miss_next;
`endif
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        seg7_decode u_dec (
            .bcd (score_bcd[g*BCD_W +: BCD_W]),
            .seg (seg[g*SEG_W +: SEG_W])
        );
    end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Scoreboard bench for score_bcd_counter: integer score model, queued expectations, decoupled monitor.
module tb_score_bcd_counter;

    localparam int N_CH     = 2;
    localparam int N_DIGITS = 2;
    localparam int MAXS     = 99;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      clr;
    logic [N_CH-1:0]           pb;
    logic [N_CH-1:0]           mole;
    logic [4*N_DIGITS-1:0]     score_bcd;
    logic [7*N_DIGITS-1:0]     seg;
    logic                      hit_pulse;
    logic                      sat;
`ifdef SCORE_PENALTY_EN
    logic                      miss_pulse;
`endif

    score_bcd_counter #(.N_CH(N_CH), .N_DIGITS(N_DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .pb        (pb),
        .mole      (mole),
        .score_bcd (score_bcd),
        .seg       (seg),
        .hit_pulse (hit_pulse),
`ifdef SCORE_PENALTY_EN
        .miss_pulse(miss_pulse),
`endif
        .sat       (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int score;
        bit hit;
        bit miss;
        bit sat;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hit_count = 0;

    // Model state
    int              m_score = 0;
    logic [N_CH-1:0] m_prev  = '0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0011000};

    function automatic logic [4*N_DIGITS-1:0] to_bcd(input int s);
        logic [4*N_DIGITS-1:0] r;
        int v;
        r = '0;
        v = s;
        for (int i = 0; i < N_DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [7*N_DIGITS-1:0] to_seg(input int s);
        logic [7*N_DIGITS-1:0] r;
        int v;
        r = '0;
        v = s;
        for (int i = 0; i < N_DIGITS; i++) begin
            r[i*7 +: 7] = seg_tab[v % 10];
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model predicts the state after the next rising edge.
    task automatic drive(input logic [N_CH-1:0] p, input logic [N_CH-1:0] m, input logic c);
        exp_t e;
        logic [N_CH-1:0] pr;
        @(negedge clk);
        pb   = p;
        mole = m;
        clr  = c;
        pr = p & ~m_prev;
        e.hit  = 1'b0;
        e.miss = 1'b0;
        if (c) begin
            m_score = 0;
        end else if ((pr & m) != 0) begin
            e.hit = 1'b1;
            if (m_score < MAXS) m_score++;
`ifdef SCORE_PENALTY_EN
        end else if ((pr & ~m) != 0) begin
            e.miss = 1'b1;
            if (m_score > 0) m_score--;
`endif
        end
        m_prev  = p;
        e.score = m_score;
        e.sat   = (m_score == MAXS);
        q.push_back(e);
    endtask

    task automatic tap(input int ch, input logic [N_CH-1:0] m);
        drive(N_CH'(1) << ch, m, 1'b0);
        drive('0, m, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_score"}, 32'(score_bcd), 32'(0));
        chk({tag, "_seg"},   32'(seg), 32'(to_seg(0)));
        chk({tag, "_hit"},   32'(hit_pulse), 32'(0));
        chk({tag, "_sat"},   32'(sat), 32'(0));
`ifdef SCORE_PENALTY_EN
        chk({tag, "_miss"},  32'(miss_pulse), 32'(0));
`endif
    endtask

    // Monitor: one expectation per rising edge while stimulus is queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_score", 32'(score_bcd), 32'(to_bcd(e.score)));
                chk("sb_seg",   32'(seg), 32'(to_seg(e.score)));
                chk("sb_hit",   32'(hit_pulse), 32'(e.hit));
                chk("sb_sat",   32'(sat), 32'(e.sat));
`ifdef SCORE_PENALTY_EN
                chk("sb_miss",  32'(miss_pulse), 32'(e.miss));
`endif
                if (hit_pulse) hit_count++;
            end
        end
    end

    initial begin
        reset = 1'b1;
        clr   = 1'b0;
        pb    = '0;
        mole  = '0;
        #23;
        chk_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Three single-cycle taps on channel 0
        hit_count = 0;
        for (int i = 0; i < 3; i++) tap(0, 2'b01);
        @(posedge clk); #2;
        chk("three_taps", 32'(score_bcd), 32'h03);
        chk("three_taps_seg0", 32'(seg[6:0]), 32'(7'b0110000));
        chk("three_pulses", 32'(hit_count), 32'(3));

        // Held button counts once
        for (int i = 0; i < 10; i++) drive(2'b01, 2'b01, 1'b0);
        drive('0, 2'b01, 1'b0);
        @(posedge clk); #2;
        chk("held_once", 32'(score_bcd), 32'h04);

        // Mole appearing while button already held does not count
        drive(2'b10, 2'b00, 1'b0);
        drive(2'b10, 2'b10, 1'b0);
        drive('0, 2'b00, 1'b0);

        // Up through the carry and into saturation
        while (m_score < 10) tap(0, 2'b01);
        @(posedge clk); #2;
        chk("carry_seg1", 32'(seg[13:7]), 32'(7'b1111001));
        while (m_score < MAXS) tap(1, 2'b10);
        @(posedge clk); #2;
        chk("sat_high", 32'(sat), 32'(1));
        drive(2'b01, 2'b01, 1'b0);
        @(posedge clk); #2;
        chk("sat_hold", 32'(score_bcd), 32'h99);
        chk("sat_hit_pulse", 32'(hit_pulse), 32'(1));
        drive('0, 2'b00, 1'b0);

        // Clear, then dual hit counts once, then clr beats a hit
        drive('0, 2'b00, 1'b1);
        drive(2'b11, 2'b11, 1'b0);
        drive('0, 2'b11, 1'b0);
        @(posedge clk); #2;
        chk("dual_hit", 32'(score_bcd), 32'h01);
        drive(2'b01, 2'b01, 1'b1);
        @(posedge clk); #2;
        chk("clr_score", 32'(score_bcd), 32'h00);
        chk("clr_no_pulse", 32'(hit_pulse), 32'(0));
        drive('0, 2'b00, 1'b0);

`ifdef SCORE_PENALTY_EN
        while (m_score < 10) tap(0, 2'b01);
        tap(0, 2'b00);
        @(posedge clk); #2;
        chk("miss_borrow", 32'(score_bcd), 32'h09);
        drive('0, 2'b00, 1'b1);
        tap(1, 2'b00);
        drive(2'b11, 2'b01, 1'b0);
        drive('0, 2'b00, 1'b0);
        @(posedge clk); #2;
        chk("hit_beats_miss", 32'(score_bcd), 32'h01);
`endif

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive(N_CH'($urandom_range(0, 3)), N_CH'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) == 0));
        end

        // Asynchronous reset between clock edges
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk_reset_state("async_reset");
        m_score = 0;
        m_prev  = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        tap(0, 2'b01);
        @(posedge clk); #2;
        chk("post_reset_press", 32'(score_bcd), 32'h01);

        for (int i = 0; i < 3; i++) drive('0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/score_bcd_counter.md
# score_bcd_counter

Parametrised score counter for the whack-a-mole game: samples N_CH player buttons against the N_CH mole-enable lines and counts hits. The count is held as an N_DIGITS-wide BCD value and drives active-low seven-segment patterns, one group per digit. It sits between the debounced button inputs / LFSR mole generator and the display multiplexer. It replaces the single-digit, button-clocked score counter with a fully synchronous, saturating, multi-digit design.

## Interface
Parameters:
- N_CH, 2: number of button/mole channel pairs (1..8).
- N_DIGITS, 2: number of BCD score digits (1..4); maximum score is 10^N_DIGITS − 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous game clear; score returns to 0.
- pb  in  N_CH  debounced, clk-synchronous buttons, active-high.
- mole  in  N_CH  mole-visible flags, active-high, clk-synchronous.
- score_bcd  out  4*N_DIGITS  registered score; digit 0 (units) in bits [3:0].
- seg  out  7*N_DIGITS  active-low segments per digit, order {g,f,e,d,c,b,a}; digit 0 in bits [6:0].
- hit_pulse  out  1  registered one-cycle pulse when a hit is counted.
- sat  out  1  high while score equals maximum.

## Operation
- Per-channel rising-edge detect: pb_q register. A press is pb[i] & ~pb_q[i].
- Hit: press[i] & mole[i] on any i. Several hits in one cycle count as one increment.
- Increment: BCD add 1 with ripple carry across digits. A digit at 9 wraps to 0 and carries into the next digit.
- Saturation: at all-9s, a hit leaves the score unchanged. sat=1. hit_pulse still asserts.
- clr has priority over hit and miss. It zeroes score_bcd and produces no hit_pulse. pb_q still updates.
- seg is decoded combinationally from score_bcd. Patterns 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000.
- Non-BCD digit values are unreachable. If one is ever present, the decoder drives 1111111 (blank).

## Timing
- Reset values: score_bcd=0, pb_q=0, hit_pulse=0, sat=0, and seg = 1000000 repeated N_DIGITS times.
- Reset mid-operation clears everything immediately, regardless of clk. The first press after reset release is detected normally.
- Latency: a press sampled at edge k updates score_bcd and hit_pulse at edge k.
  - Both are visible in cycle k+1.
  - seg follows score_bcd in the same cycle.
  - sat is registered and asserts together with the score reaching the maximum.
- A button held high counts once. It must go low for at least one cycle before it can count again.
- mole is sampled only in the press cycle. A mole appearing while the button is held does not count.

## Configuration
- SCORE_PENALTY_EN defined:
  - A miss is a press on a channel whose mole is low.
  - A miss decrements the score by 1 in BCD with borrow; a digit at 0 becomes 9 and borrows from the next digit.
  - The score floors at 0: a miss at 0 leaves the score at 0.
  - If a hit and a miss occur in the same cycle, the hit wins: increment only.
  - Output miss_pulse (1 bit, registered, reset 0) pulses for one cycle on every detected miss, including misses at the floor.
- SCORE_PENALTY_EN undefined: misses are ignored and the miss_pulse port is absent.

## Structure
- Shared package score_pkg holds:
  - SEG_W = 7 and BCD_W = 4
  - the ten segment constants SEG_0..SEG_9 and SEG_BLANK
  - the typedef bcd_digit_t (logic [3:0]).
- One sub-module, seg7_decode: 4-bit BCD in, 7-bit active-low segments out, purely combinational. It is instantiated N_DIGITS times in a generate loop.
- The BCD increment/decrement chain stays inline in score_bcd_counter.

## Test plan
- Reset with defaults: expect score_bcd=0x00, seg=14'b1000000_1000000, sat=0, hit_pulse=0.
- mole=2'b01, pb[0] pulsed for 1 cycle ×3: expect score_bcd=0x03, seg digit0=0110000, and three hit_pulse cycles.
- pb[0] held high for 10 cycles with mole[0]=1: expect the score to advance by exactly 1.
- Nine hits, then one more: 0x09 → 0x10 (carry), digit1 seg=1111001. Drive to 0x99: sat=1. One further hit: score stays 0x99 and hit_pulse=1.
- Both channels pressed in the same cycle with mole=2'b11: expect +1 only. Then assert clr in the same cycle as a hit: expect score 0x00 and no hit_pulse.
- With SCORE_PENALTY_EN, score 0x10, press with mole=0: expect 0x09 and miss_pulse=1. At 0x00, a miss leaves 0x00. A hit plus a miss in the same cycle gives +1.
